// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: MEM/WB writeback control layout and datapath widths.
// Imported by the MEM/WB register, the forwarding unit and the writeback stage.
package wb_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Bit positions inside the 2-bit control_wb field.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_reg_array.sv
// Architectural register storage: one synchronous write port, two raw
// combinational read ports, async active-low clear of every entry.
module wb_regfile_reg_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: this array is deliberately reset; architectural state must read 0
  // after reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule : wb_regfile_reg_array

// File: rtl/wb_regfile.sv
// MIPS writeback stage: result select, register-file commit with write-before-read
// bypass on both decode ports, forwarding export and retire counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_control_wb,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] mem_ALU_result,
  input  logic [ADDR_W-1:0] mem_write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic              w_wb_en;
  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_raw_rs;
  logic [DATA_W-1:0] w_raw_rt;
  logic [CNT_W-1:0]  r_retire_count;

  // Writes aimed at r0 are squashed here so neither the array nor the counter sees them.
  assign w_wb_data = mem_control_wb[WB_MEMTOREG] ? read_data : mem_ALU_result;
  assign w_wb_en   = mem_control_wb[WB_REGWRITE] && (mem_write_reg != '0);

  assign wb_en   = w_wb_en;
  assign wb_reg  = mem_write_reg;
  assign wb_data = w_wb_data;

  wb_regfile_reg_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_array (
    .clk       (clk),
    .rst_n     (reset),
    .i_we      (w_wb_en),
    .i_waddr   (mem_write_reg),
    .i_wdata   (w_wb_data),
    .i_raddr_a (rs_addr),
    .i_raddr_b (rt_addr),
    .o_rdata_a (w_raw_rs),
    .o_rdata_b (w_raw_rt)
  );

  function automatic logic [DATA_W-1:0] resolve_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] raw
  );
    if (addr == '0)                            return '0;
    else if (w_wb_en && mem_write_reg == addr) return w_wb_data;
    else                                       return raw;
  endfunction

  assign rs_data = resolve_read(rs_addr, w_raw_rs);
  assign rt_data = resolve_read(rt_addr, w_raw_rt);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_count <= '0;
    end else if (w_wb_en) begin
      r_retire_count <= r_retire_count + CNT_W'(1);
    end
  end

  assign retire_count = r_retire_count;

endmodule : wb_regfile
